// File: rtl/alu_slice_pkg.sv
// alu_slice_pkg: op encodings and default width shared by the ALU slice unit
package alu_slice_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] OP_NAND    = 2'b00;
  localparam logic [1:0] OP_XNOR    = 2'b01;
  localparam logic [1:0] OP_NOR_NB  = 2'b10;
  localparam logic [1:0] OP_ADD_INV = 2'b11;
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one ALU bit with operand inversion, gates, full adder and result mux
module alu_bit_slice
  import alu_slice_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  input  logic s0,
  input  logic s1,
  output logic y,
  output logic co
);
  logic ia, ib, sum;
  logic [1:0] op;
  always_comb begin
    op  = {s1, s0};
    ia  = a ^ s0;
    ib  = b ^ s1;
    sum = ia ^ ib ^ ci;
    co  = (ia & ib) | (ci & (ia ^ ib));
    y   = op == OP_ADD_INV ? sum :
          op == OP_NOR_NB  ? ~(ia | ib) :
          op == OP_XNOR    ? ia ^ ib : ~(ia & ib);
  end
endmodule

// File: rtl/alu_slice_unit.sv
// alu_slice_unit: registered N-bit ALU built from ripple-chained bit slices
module alu_slice_unit
  import alu_slice_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
);
  logic [WIDTH:0]   ci;
  logic [WIDTH-1:0] y;
  assign ci[0] = c;
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a (a[i]),
      .b (b[i]),
      .ci(ci[i]),
      .s0(s0),
      .s1(s1),
      .y (y[i]),
      .co(ci[i+1])
    );
  end
  // equal-sign operands with a differing sum sign is exactly carry-into-MSB != carry-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= y;
        carry    <= ci[WIDTH];
        zero     <= ~|y;
        overflow <= ci[WIDTH] ^ ci[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_alu_slice_unit.sv
// tb_alu_slice_unit: directed and random checks of alu_slice_unit against an arithmetic model
module tb_alu_slice_unit;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         s0 = 1'b0;
  logic         s1 = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c = 1'b0;
  logic [W-1:0] result;
  logic         carry, zero, overflow, out_valid;
  logic [W-1:0] e_result = '0;
  logic         e_carry = 1'b0, e_zero = 1'b0, e_ovf = 1'b0, e_valid = 1'b0;
  int           checks = 0;
  int           errors = 0;

  alu_slice_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s0(s0), .s1(s1),
    .a(a), .b(b), .c(c), .result(result), .carry(carry), .zero(zero),
    .overflow(overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".result"}, 32'(result), 32'(e_result));
    chk({tag, ".carry"}, 32'(carry), 32'(e_carry));
    chk({tag, ".zero"}, 32'(zero), 32'(e_zero));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
  endtask

  task automatic model(input logic v, input logic [1:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] z, input logic cin);
    logic [W-1:0] ia, ib;
    logic [W:0]   s;
    int           t;
    e_valid = v;
    if (v) begin
      ia = op[0] ? ~x : x;
      ib = op[1] ? ~z : z;
      s  = {1'b0, ia} + {1'b0, ib} + (W+1)'(cin);
      t  = int'($signed(ia)) + int'($signed(ib)) + int'(cin);
      case (op)
        2'b00:   e_result = ~(x & z);
        2'b01:   e_result = ~(x ^ z);
        2'b10:   e_result = ~(x | ~z);
        default: e_result = s[W-1:0];
      endcase
      e_carry = s[W];
      e_zero  = (e_result == '0);
      e_ovf   = (t > (2**(W-1) - 1)) || (t < -(2**(W-1)));
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] op,
                      input logic [W-1:0] x, input logic [W-1:0] z, input logic cin);
    in_valid = v; s1 = op[1]; s0 = op[0]; a = x; b = z; c = cin;
    model(v, op, x, z, cin);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    @(posedge clk); #1;
    e_result = '0; e_carry = 0; e_zero = 0; e_ovf = 0; e_valid = 0;
    chk_all("reset");
    rst_n = 1'b1;
    step("nand", 1, 2'b00, 8'hF0, 8'hCC, 0);
    chk("nand.lit", 32'(result), 32'h3F);
    step("xnor", 1, 2'b01, 8'hF0, 8'hCC, 0);
    chk("xnor.lit", 32'(result), 32'hC3);
    step("nor_nb", 1, 2'b10, 8'hF0, 8'hCC, 0);
    chk("nor_nb.lit", 32'(result), 32'h0C);
    chk("nor_nb.carry_lit", 32'(carry), 32'h1);
    step("add0", 1, 2'b11, 8'h00, 8'h00, 0);
    chk("add0.lit", 32'(result), 32'hFE);
    step("add1", 1, 2'b11, 8'hFE, 8'hFF, 1);
    chk("add1.lit", 32'(result), 32'h02);
    step("add_ovf", 1, 2'b11, 8'h80, 8'h80, 1);
    chk("add_ovf.lit", 32'(overflow), 32'h1);
    step("add_zero", 1, 2'b11, 8'hFF, 8'hFF, 0);
    chk("add_zero.lit", 32'(zero), 32'h1);
    step("thr1", 1, 2'b00, 8'h5A, 8'h3C, 0);
    step("gap", 0, 2'b11, 8'h11, 8'h22, 1);
    step("gap2", 0, 2'b01, 8'hAA, 8'h55, 0);
    step("thr2", 1, 2'b01, 8'h12, 8'h34, 0);
    step("thr3", 1, 2'b10, 8'h77, 8'h0F, 1);
    in_valid = 1; s1 = 1; s0 = 1; a = 8'h33; b = 8'h44; c = 1;
    #2 rst_n = 1'b0;
    #1;
    e_result = '0; e_carry = 0; e_zero = 0; e_ovf = 0; e_valid = 0;
    chk_all("async_reset");
    @(posedge clk); #1;
    chk_all("reset_hold");
    rst_n = 1'b1;
    step("post_reset_idle", 0, 2'b11, 8'h33, 8'h44, 1);
    step("post_reset_go", 1, 2'b11, 8'h33, 8'h44, 1);
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(3) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
